// File: rtl/spike_arb_pkg.sv
// Shared widths and AER event payload for the spike round-robin arbiter.
package spike_arb_pkg;

  localparam int unsigned N_REQ_DEF = 16;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned EVT_W     = 8;
  localparam int unsigned TS_W      = 8;
  localparam int unsigned REQ_IDX_W = EVT_W - ADDR_W;
  localparam int unsigned CNT_W     = 5;

  // AER event word: requester index in the upper nibble, local neuron address below
  typedef struct packed {
    logic [REQ_IDX_W-1:0] req_idx;
    logic [ADDR_W-1:0]    addr;
  } aer_evt_t;

endpackage

// File: rtl/spike_evt_fifo.sv
// Synchronous event FIFO with occupancy count; head is presented combinationally
// and reads as zero while empty. Push is refused when full unless a pop happens
// in the same cycle; pop is ignored while empty.
module spike_evt_fifo
  import spike_arb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = EVT_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              valid,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              push_eff;
  logic              pop_eff;

  // Qualify push/pop against occupancy and compute next pointers, count and storage
  always_comb begin
    pop_eff  = pop && (count_q != '0);
    push_eff = push && ((count_q < CNT_W'(DEPTH)) || pop_eff);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_eff);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_eff);
    count_d  = count_q + CNT_W'(push_eff) - CNT_W'(pop_eff);
    mem_d    = mem_q;
    if (push_eff) begin
      mem_d[wr_ptr_q] = wdata;
    end
  end

  // FIFO state registers; reset empties the buffer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  // Head presentation, zero while empty
  always_comb begin
    valid = (count_q != '0);
    count = count_q;
    rdata = valid ? mem_q[rd_ptr_q] : '0;
  end

endmodule

// File: rtl/spike_rr_arbiter.sv
// Round-robin spike arbiter feeding an AER event FIFO.
// Optional feature: define SPIKE_ARB_TIMESTAMP_EN to add the 8-bit tick counter,
// per-entry timestamp storage and the ev_ts output.
module spike_rr_arbiter
  import spike_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = N_REQ_DEF,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [N_REQ-1:0]      spikes_in,
  input  logic [N_REQ*ADDR_W-1:0] addr_in,
  output logic [N_REQ-1:0]      acks_out,
  output logic                  ev_valid,
  input  logic                  ev_ready,
  output logic [EVT_W-1:0]      ev_addr,
`ifdef SPIKE_ARB_TIMESTAMP_EN
  output logic [TS_W-1:0]       ev_ts,
`endif
  output logic [CNT_W-1:0]      ev_count
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
`ifdef SPIKE_ARB_TIMESTAMP_EN
  localparam int unsigned FIFO_W = EVT_W + TS_W;
`else
  localparam int unsigned FIFO_W = EVT_W;
`endif

  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  win_idx;
  logic [ADDR_W-1:0] win_addr;
  logic              grant_found;
  logic              pop_c;
  logic              push_ok_c;
  logic              grant_c;
  aer_evt_t          win_evt;
  logic [FIFO_W-1:0] fifo_wdata;
  logic [FIFO_W-1:0] fifo_rdata;
  logic              fifo_valid;
  logic [CNT_W-1:0]  fifo_count;

  // First pending requester at or after rr_ptr, wrapping through N_REQ-1 -> 0
  always_comb begin
    logic [IDX_W-1:0] cand;
    grant_found = 1'b0;
    win_idx     = '0;
    cand        = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      cand = rr_ptr_q + IDX_W'(k);
      if (!grant_found && spikes_in[cand]) begin
        grant_found = 1'b1;
        win_idx     = cand;
      end
    end
  end

  // Address slice of the winning requester
  always_comb begin
    win_addr = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (IDX_W'(i) == win_idx) begin
        win_addr = addr_in[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Grant only when the FIFO can take the event this edge; ack is same-cycle
  always_comb begin
    pop_c         = fifo_valid && ev_ready;
    push_ok_c     = (fifo_count < CNT_W'(FIFO_DEPTH)) || pop_c;
    grant_c       = resetn && push_ok_c && grant_found;
    acks_out      = grant_c ? (N_REQ'(1) << win_idx) : '0;
    rr_ptr_d      = grant_c ? (win_idx + IDX_W'(1)) : rr_ptr_q;
    win_evt.req_idx = REQ_IDX_W'(win_idx);
    win_evt.addr    = win_addr;
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef SPIKE_ARB_TIMESTAMP_EN
  logic [TS_W-1:0] tick_q, tick_d;

  // Free-running tick counter, wraps naturally at 255 -> 0
  always_comb begin
    tick_d = tick_q + TS_W'(1);
  end

  // Tick counter register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

  // Timestamp rides above the AER word in each entry
  always_comb begin
    fifo_wdata = {tick_q, win_evt};
    ev_ts      = fifo_rdata[FIFO_W-1:EVT_W];
  end
`else
  // AER word is the whole entry
  always_comb begin
    fifo_wdata = win_evt;
  end
`endif

  spike_evt_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (FIFO_W)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (grant_c),
    .pop    (pop_c),
    .wdata  (fifo_wdata),
    .rdata  (fifo_rdata),
    .valid  (fifo_valid),
    .count  (fifo_count)
  );

  // Event-side outputs straight from the FIFO head
  always_comb begin
    ev_valid = fifo_valid;
    ev_count = fifo_count;
    ev_addr  = fifo_rdata[EVT_W-1:0];
  end

endmodule

// File: tb/tb_spike_rr_arbiter.sv
// Self-checking bench for spike_rr_arbiter against a queue-based event model.
module tb_spike_rr_arbiter;

  localparam int NR    = 16;
  localparam int DEPTH = 4;

  logic          clk;
  logic          resetn;
  logic [NR-1:0] spikes_in;
  logic [NR*4-1:0] addr_in;
  logic [NR-1:0] acks_out;
  logic          ev_valid;
  logic          ev_ready;
  logic [7:0]    ev_addr;
  logic [7:0]    ev_ts;
  logic [4:0]    ev_count;

  spike_rr_arbiter #(.N_REQ(NR), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .spikes_in (spikes_in),
    .addr_in   (addr_in),
    .acks_out  (acks_out),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_addr   (ev_addr),
`ifdef SPIKE_ARB_TIMESTAMP_EN
    .ev_ts     (ev_ts),
`endif
    .ev_count  (ev_count)
  );

`ifndef SPIKE_ARB_TIMESTAMP_EN
  assign ev_ts = 8'h00;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: queued events {ts, idx, addr}, rr pointer, pending requests
  logic [15:0]   q[$];
  int            rr;
  logic [NR-1:0] pend;
  logic [3:0]    addrs[NR];
  bit            rdy;
  logic [7:0]    tcnt;
  logic [15:0]   seen_ack;
  logic [7:0]    seen_addr;
  logic [7:0]    seen_ts;
  int            n_tests;
  int            n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive, check against model at the falling edge, update model at the rising edge
  task automatic tick();
    int         widx;
    int         idx;
    bit         found;
    bit         pop;
    bit         push_ok;
    logic [15:0] exp_ack;
    logic [15:0] head;
    spikes_in = pend;
    for (int i = 0; i < NR; i++) addr_in[i*4 +: 4] = addrs[i];
    ev_ready = rdy;
    #4;
    pop     = (q.size() != 0) && rdy;
    push_ok = (q.size() < DEPTH) || pop;
    found   = 0;
    widx    = 0;
    for (int k = 0; k < NR; k++) begin
      idx = (rr + k) % NR;
      if (!found && pend[idx]) begin
        found = 1;
        widx  = idx;
      end
    end
    exp_ack = (found && push_ok) ? (16'h0001 << widx) : 16'h0000;
    head    = (q.size() != 0) ? q[0] : 16'h0000;
    check("acks_out", 32'(acks_out), 32'(exp_ack));
    check("ev_valid", 32'(ev_valid), 32'(q.size() != 0));
    check("ev_addr", 32'(ev_addr), 32'(head[7:0]));
    check("ev_count", 32'(ev_count), 32'(q.size()));
`ifdef SPIKE_ARB_TIMESTAMP_EN
    check("ev_ts", 32'(ev_ts), 32'(head[15:8]));
`endif
    seen_ack  = acks_out;
    seen_addr = ev_addr;
    seen_ts   = ev_ts;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (found && push_ok) begin
      q.push_back({tcnt, 4'(widx), addrs[widx]});
      rr = (widx + 1) % NR;
      pend[widx] = 1'b0;
    end
    tcnt = tcnt + 8'd1;
    #1;
  endtask

  // Reset held across one rising edge with all requesters asserted
  task automatic do_reset();
    resetn    = 1'b0;
    spikes_in = 16'hFFFF;
    ev_ready  = 1'b1;
    #3;
    check("rst_acks", 32'(acks_out), 32'h0);
    check("rst_valid", 32'(ev_valid), 32'h0);
    check("rst_count", 32'(ev_count), 32'h0);
    check("rst_addr", 32'(ev_addr), 32'h0);
    @(posedge clk);
    #1;
    check("rst_acks_edge", 32'(acks_out), 32'h0);
    resetn = 1'b1;
    q.delete();
    rr   = 0;
    pend = '0;
    tcnt = 8'd0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    resetn  = 1'b0;
    spikes_in = 16'hFFFF;
    addr_in = '0;
    ev_ready = 1'b0;
    rdy  = 0;
    pend = '0;
    rr   = 0;
    tcnt = 8'd0;
    for (int i = 0; i < NR; i++) addrs[i] = 4'(i);
    @(posedge clk);
    #1;

    // Reset with every requester pending, then first grant goes to requester 0
    do_reset();
    pend = 16'hFFFF;
    rdy  = 0;
    tick();
    check("first_ack", 32'(seen_ack), 32'h0001);

    // Fairness between requesters 0 and 15
    do_reset();
    addrs[0]  = 4'ha;
    addrs[15] = 4'hb;
    rdy = 1;
    pend = 16'h8001;
    tick();
    check("fair_g0", 32'(seen_ack), 32'h0001);
    pend = pend | 16'h8001;
    tick();
    check("fair_g1", 32'(seen_ack), 32'h8000);
    check("fair_a0", 32'(seen_addr), 32'h0a);
    pend = pend | 16'h8001;
    tick();
    check("fair_g2", 32'(seen_ack), 32'h0001);
    check("fair_a1", 32'(seen_addr), 32'hfb);
    pend = pend | 16'h8001;
    tick();
    check("fair_g3", 32'(seen_ack), 32'h8000);

    // Full FIFO backpressure, then push alongside a pop
    do_reset();
    rdy  = 0;
    pend = 16'h001F;
    for (int i = 0; i < 6; i++) tick();
    check("full_count", 32'(ev_count), 32'd4);
    check("full_pend4", 32'(pend[4]), 32'h1);
    rdy = 1;
    tick();
    check("full_popack", 32'(seen_ack), 32'h0010);
    rdy = 0;
    tick();
    check("full_keep", 32'(ev_count), 32'd4);

    // Pointer wrap: grant 14, then 3 alone, then 3 and 4 tie resolved from rr=4
    do_reset();
    rdy  = 1;
    pend = 16'h4000;
    tick();
    pend = 16'h0008;
    tick();
    check("wrap_ack3", 32'(seen_ack), 32'h0008);
    pend = 16'h0018;
    tick();
    check("wrap_ptr4", 32'(seen_ack), 32'h0010);
    tick();

    // Mid-operation reset discards buffered events
    do_reset();
    rdy  = 0;
    pend = 16'h0007;
    for (int i = 0; i < 3; i++) tick();
    check("mid_count3", 32'(ev_count), 32'd3);
    do_reset();
    rdy = 1;
    for (int i = 0; i < 4; i++) tick();

`ifdef SPIKE_ARB_TIMESTAMP_EN
    // Timestamps across the 8-bit wrap keep order
    do_reset();
    rdy  = 0;
    while (tcnt != 8'd254) tick();
    pend = 16'h0001;
    tick();
    while (tcnt != 8'd1) tick();
    pend = 16'h0002;
    tick();
    rdy = 1;
    tick();
    check("ts_first", 32'(seen_ts), 32'hfe);
    tick();
    check("ts_second", 32'(seen_ts), 32'h01);
`endif

    // Randomized traffic with varying backpressure and occasional resets
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [NR-1:0] nw;
      nw = NR'($urandom & $urandom & $urandom);
      for (int i = 0; i < NR; i++) begin
        if (nw[i] && !pend[i]) addrs[i] = 4'($urandom_range(0, 15));
      end
      pend = pend | nw;
      if (c < 1000)      rdy = ($urandom_range(0, 3) == 0);
      else if (c < 2000) rdy = ($urandom_range(0, 1) == 0);
      else               rdy = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
